// File: rtl/mcpu5_pkg.sv
// Shared definitions for the MCPU5 host driver: core opcodes and the host state encoding.
package mcpu5_pkg;

  localparam logic [5:0] OP_OUT = 6'b111001;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_JCC = 2'b00;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [5:0] OP_NOT = 6'b111000;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STALL = 2'd3
  } host_state_t;

endpackage

// File: rtl/mcpu5_prog_ram.sv
// 256x6 program store: synchronous write, asynchronous read, contents survive reset.
module mcpu5_prog_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [5:0] wdata,
  input  logic [7:0] raddr,
  output logic [5:0] rdata
);

  logic [5:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mcpu5_host.sv
// Host side of the MCPU5 core: generates core clock/reset, feeds instructions
// from the program RAM and captures OUT results into a one-entry buffer.
module mcpu5_host
  import mcpu5_pkg::*;
#(
  parameter int HALF       = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [5:0]  prog_data,
  output logic        cpu_clk,
  output logic        cpu_rst,
  output logic [5:0]  cpu_inst,
  input  logic [7:0]  cpu_out,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [7:0]  pc_mon,
  output host_state_t state_mon
);

  localparam int CW = $clog2(HALF);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FETCH = CW'(HALF - 2);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES);

  host_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] edges_q, edges_d;
  logic          clk_d, rst_d;
  logic          cap_q, cap_d;
  logic          load;
  logic          out_pending;
  logic [5:0]    inst_d;
  logic [5:0]    ram_rdata;
  logic [7:0]    pc_d;

  assign state_mon   = state_q;
  // cap_q marks that this low phase's OUT word is already taken, so a frozen
  // LOW (run=0) or the exit from STALL never captures the same word twice.
  assign out_pending = (cpu_inst == OP_OUT) && !cap_q;

  mcpu5_prog_ram u_ram (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (cpu_out),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edges_d = edges_q;
    clk_d   = cpu_clk;
    rst_d   = cpu_rst;
    inst_d  = cpu_inst;
    pc_d    = pc_mon;
    cap_d   = cap_q;
    load    = 1'b0;
    case (state_q)
      ST_RST: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          clk_d = ~cpu_clk;
          if (!cpu_clk) begin
            edges_d = edges_q + RW'(1);
          end else if (edges_q == RST_LAST) begin
            rst_d   = 1'b0;
            state_d = ST_LOW;
          end
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_FETCH) begin
          pc_d   = cpu_out;
          inst_d = ram_rdata;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          clk_d   = 1'b0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (out_pending && out_valid && !out_ready) begin
          state_d = ST_STALL;
        end else begin
          if (out_pending) begin
            load  = 1'b1;
            cap_d = 1'b1;
          end
          if (run) begin
            state_d = ST_HIGH;
            clk_d   = 1'b1;
            cnt_d   = '0;
            cap_d   = 1'b0;
          end
        end
      end
      ST_STALL: begin
        if (out_ready) begin
          load    = 1'b1;
          cap_d   = 1'b1;
          state_d = ST_LOW;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RST;
      cnt_q    <= '0;
      edges_q  <= '0;
      cpu_clk  <= 1'b0;
      cpu_rst  <= 1'b1;
      cpu_inst <= '0;
      pc_mon   <= '0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edges_q  <= edges_d;
      cpu_clk  <= clk_d;
      cpu_rst  <= rst_d;
      cpu_inst <= inst_d;
      pc_mon   <= pc_d;
      cap_q    <= cap_d;
    end
  end

  // Output handshake: a word moves on any clk edge where out_valid & out_ready;
  // a capture in that same cycle refills the buffer, otherwise it empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= cpu_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcpu5_host.sv
// Bench for mcpu5_host: a behavioural MCPU5 core answers on the bus, and the
// OUT stream is checked against constants or an instruction-level interpreter.
module tb_mcpu5_host;
  import mcpu5_pkg::*;

  localparam int HALF       = 4;
  localparam int RST_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b1;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [5:0]  prog_data = '0;
  logic        cpu_clk, cpu_rst;
  logic [5:0]  cpu_inst;
  logic [7:0]  cpu_out;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [7:0]  pc_mon;
  host_state_t state_mon;

  int n_vec = 0;
  int n_err = 0;
  int rst_edges = 0;

  logic [5:0] pb[$];
  logic [5:0] prog_img [256];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  mcpu5_host #(.HALF(HALF), .RST_CYCLES(RST_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .cpu_inst  (cpu_inst),
    .cpu_out   (cpu_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .pc_mon    (pc_mon),
    .state_mon (state_mon)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural core: executes cpu_inst on each rising cpu_clk
  logic [7:0] c_pc = '0, c_acc = '0;
  logic       c_cy = 1'b0;
  logic [7:0] c_r [8];

  always @(posedge cpu_clk) begin
    if (cpu_rst) begin
      c_pc <= '0; c_acc <= '0; c_cy <= 1'b0;
      for (int i = 0; i < 8; i++) c_r[i] <= '0;
    end else begin
      c_pc <= c_pc + 8'd1;
      casez (cpu_inst)
        6'b00????: if (!c_cy) c_pc <= {4'b0, cpu_inst[3:0]}; else c_cy <= 1'b0;
        6'b01????: c_acc <= {{4{cpu_inst[3]}}, cpu_inst[3:0]};
        6'b100???: {c_cy, c_acc} <= {1'b0, c_acc} + {1'b0, c_r[cpu_inst[2:0]]};
        6'b101???: c_r[cpu_inst[2:0]] <= c_acc;
        6'b111000: c_acc <= ~c_acc;
        default: ;
      endcase
    end
  end

  assign cpu_out = cpu_clk ? c_pc : c_acc;

  // monitors
  always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
  always @(posedge cpu_clk) if (cpu_rst) rst_edges++;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_prog(input bit add_spin);
    int e;
    if (add_spin) begin
      e = pb.size();
      pb.push_back({OP_JCC, 4'(e)});
      pb.push_back({OP_JCC, 4'(e)});
    end
    foreach (pb[i]) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = pb[i];
      prog_img[i] = pb[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic start_prog(input bit add_spin);
    rst_n = 1'b0;
    tick();
    load_prog(add_spin);
    got_q.delete();
    rst_n = 1'b1;
  endtask

  // mode 0: never ready, 1: always ready, 2: random
  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      out_ready = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // instruction-level reference: runs the program image, collects OUT values
  task automatic ref_run();
    logic [7:0] pc, acc;
    logic       cy;
    logic [8:0] sum;
    logic [7:0] r [8];
    logic [5:0] op;
    pc = '0; acc = '0; cy = 1'b0;
    for (int i = 0; i < 8; i++) r[i] = '0;
    exp_q.delete();
    for (int s = 0; s < 100; s++) begin
      op = prog_img[pc];
      if (op[5:4] == OP_JCC && !cy) begin
        pc = {4'b0, op[3:0]};
        continue;
      end
      if (op[5:4] == OP_JCC) cy = 1'b0;
      else if (op[5:4] == OP_LDI) acc = {{4{op[3]}}, op[3:0]};
      else if (op[5:3] == OP_ADD) begin
        sum = 9'(acc) + 9'(r[op[2:0]]);
        acc = sum[7:0]; cy = sum[8];
      end
      else if (op[5:3] == OP_STA) r[op[2:0]] = acc;
      else if (op == OP_NOT) acc = ~acc;
      else if (op == OP_OUT) exp_q.push_back(acc);
      pc = pc + 8'd1;
    end
  endtask

  initial begin
    int hi_cnt, pc_moves, n;
    logic [7:0] pc_hold;

    // reset state
    tick(); tick();
    check("rst_cpu_clk", cpu_clk, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_inst", cpu_inst, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pc_mon", pc_mon, 0);
    check("rst_state", 32'(state_mon), 32'(ST_RST));

    // LDI 5, OUT, JCC 2: one word, then spin at PC 2
    pb = '{6'b010101, OP_OUT, 6'b000010};
    start_prog(1'b0);
    run_cycles(400, 1);
    exp_q = '{8'h05};
    compare_stream("ldi5");
    check("ldi5_spin_pc", 32'(pc_mon == 8'd2 || pc_mon == 8'd3), 1);

    // LDI 5, NOT, OUT
    pb = '{6'b010101, OP_NOT, OP_OUT};
    start_prog(1'b1);
    run_cycles(300, 1);
    exp_q = '{8'hFA};
    compare_stream("not");

    // LDI -1, OUT
    pb = '{6'b011111, OP_OUT};
    start_prog(1'b1);
    run_cycles(300, 1);
    exp_q = '{8'hFF};
    compare_stream("ldim1");

    // LDI 3, STA r0, ADD r0, OUT
    pb = '{6'b010011, 6'b101000, 6'b100000, OP_OUT};
    start_prog(1'b1);
    run_cycles(300, 1);
    exp_q = '{8'h06};
    compare_stream("add3");

    // LDI -1, STA r1, ADD r1, OUT
    pb = '{6'b011111, 6'b101001, 6'b100001, OP_OUT};
    start_prog(1'b1);
    run_cycles(300, 1);
    exp_q = '{8'hFE};
    compare_stream("addm1");

    // back-pressure: three outputs with the consumer stalled
    pb = '{6'b010001, OP_OUT, 6'b010010, OP_OUT, 6'b010011, OP_OUT};
    start_prog(1'b1);
    run_cycles(100, 0);
    check("stall_state", 32'(state_mon), 32'(ST_STALL));
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 8'h01);
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (cpu_clk) hi_cnt++;
      tick();
    end
    check("stall_clk_held", hi_cnt, 0);
    run_cycles(300, 1);
    exp_q = '{8'h01, 8'h02, 8'h03};
    compare_stream("stall");

    // run=0 mid-program freezes the core clock and PC
    pb = '{6'b010001, OP_OUT, 6'b010010, OP_OUT, OP_NOT, OP_OUT, 6'b010111, OP_OUT};
    start_prog(1'b1);
    run_cycles(60, 1);
    run = 1'b0;
    run_cycles(2 * HALF + 2, 1);
    pc_hold = pc_mon;
    hi_cnt = 0; pc_moves = 0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_clk) hi_cnt++;
      if (pc_mon != pc_hold) pc_moves++;
      tick();
    end
    check("pause_clk_held", hi_cnt, 0);
    check("pause_pc_frozen", pc_moves, 0);
    check("pause_state", 32'(state_mon), 32'(ST_LOW));
    run = 1'b1;
    run_cycles(300, 1);
    exp_q = '{8'h01, 8'h02, 8'hFD, 8'h07};
    compare_stream("pause");

    // reset while stalled with a word pending; RAM keeps the program
    pb = '{6'b010001, OP_OUT, 6'b010010, OP_OUT, 6'b010011, OP_OUT};
    start_prog(1'b1);
    run_cycles(100, 0);
    check("rst2_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    check("rst2_valid", out_valid, 0);
    check("rst2_cpu_rst", cpu_rst, 1);
    check("rst2_cpu_clk", cpu_clk, 0);
    rst_edges = 0;
    got_q.delete();
    rst_n = 1'b1;
    run_cycles(300, 1);
    check("rst2_core_edges", rst_edges, RST_CYCLES);
    exp_q = '{8'h01, 8'h02, 8'h03};
    compare_stream("rst2");

    // randomized straight-line programs against the interpreter
    for (int t = 0; t < 4; t++) begin
      pb.delete();
      n = $urandom_range(4, 12);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 4))
          0: pb.push_back({OP_LDI, 4'($urandom_range(0, 15))});
          1: pb.push_back({OP_STA, 3'($urandom_range(0, 7))});
          2: pb.push_back({OP_ADD, 3'($urandom_range(0, 7))});
          3: pb.push_back(OP_NOT);
          default: pb.push_back(OP_OUT);
        endcase
      end
      pb.push_back(OP_OUT);
      start_prog(1'b1);
      ref_run();
      run_cycles(900, 2);
      run_cycles(50, 1);
      compare_stream($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
